// File: rtl/ttc_pkg.sv
// ttc_pkg: shared types and constants for the TTC lock/resync controller.
//   state_e            - controller states (RESET_DEC/SEARCH/CHECK/LOCKED)
//   STATE_W            - width of the debug state bus
//   WORD_W             - decoder word width
//   SYNC_WORD_DEFAULT  - default word-alignment pattern
//   sat_inc8()         - saturating 8-bit increment
package ttc_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned WORD_W  = 16;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 16'h817E;

    typedef enum logic [STATE_W-1:0] {
        RESET_DEC = 2'd0,
        SEARCH    = 2'd1,
        CHECK     = 2'd2,
        LOCKED    = 2'd3
    } state_e;

    // Increment that sticks at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ttc_lock_ctrl_if.sv
// ttc_lock_ctrl_if: word stream between the TTC decoder, the lock controller
// and the command layer.
//   valid_in / data_in     - decoder word strobe and word (decoder -> controller)
//   word_valid / word_data - forwarded words (controller -> command layer)
// master: the side that drives decoder words and receives forwarded words.
// slave : the lock controller.
interface ttc_lock_ctrl_if;
    import ttc_pkg::*;

    logic              valid_in;
    logic [WORD_W-1:0] data_in;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;

    modport master (
        output valid_in,
        output data_in,
        input  word_valid,
        input  word_data
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output word_valid,
        output word_data
    );

endinterface

// File: rtl/ttc_word_spacing.sv
// ttc_word_spacing: checks the spacing of decoder word strobes.
//   clk160    - clock
//   rst       - synchronous active-high reset
//   restart   - hold the checker in its initial state (driven in RESET_DEC)
//   valid     - decoder word strobe
//   misspaced - strobe arrived earlier or later than WORD_PERIOD cycles after
//               the previous reference point (never for the first strobe)
//   timeout   - 2*WORD_PERIOD cycles passed with no strobe
// misspaced/timeout are combinational pulses aligned with the current strobe.
module ttc_word_spacing #(
    parameter int unsigned WORD_PERIOD = 8
) (
    input  logic clk160,
    input  logic rst,
    input  logic restart,
    input  logic valid,
    output logic misspaced,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(2 * WORD_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_PERIOD  = CNT_W'(WORD_PERIOD);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(2 * WORD_PERIOD);

    // cnt = cycles elapsed since the last strobe (or last timeout)
    logic [CNT_W-1:0] cnt;
    logic             first;

    always_comb begin
        misspaced = valid && !restart && !first && (cnt != CNT_PERIOD);
        timeout   = !valid && !restart && (cnt == CNT_TIMEOUT);
    end

    // A timeout re-arms the counter as if a strobe had just been seen
    always_ff @(posedge clk160) begin
        if (rst || restart) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (valid) begin
            cnt   <= CNT_W'(1);
            first <= 1'b0;
        end else if (timeout) begin
            cnt   <= CNT_W'(1);
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ttc_lock_ctrl.sv
// ttc_lock_ctrl: lock and resynchronisation controller for the TTC decoder.
//   clk160        - sole clock
//   rst           - synchronous active-high reset
//   bus (slave)   - valid_in/data_in from the decoder, word_valid/word_data
//                   to the command layer (forwarded only while locked)
//   dec_rst       - decoder reset pulse, RST_CYCLES long
//   locked        - high in LOCKED
//   lock_loss_cnt - LOCKED->RESET_DEC transitions, saturating at 255
//   state         - current FSM state (debug)
// Build option: define TTC_LOCK_SYNC_FILTER_EN to drop sync words from the
// forwarded stream; by default every accepted word is forwarded.
module ttc_lock_ctrl
    import ttc_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int unsigned       WORD_PERIOD    = 8,
    parameter int unsigned       LOCK_COUNT     = 32,
    parameter int unsigned       UNLOCK_COUNT   = 4,
    parameter int unsigned       SYNC_GAP_MAX   = 64,
    parameter int unsigned       SEARCH_TIMEOUT = 4096,
    parameter int unsigned       RST_CYCLES     = 16
) (
    input  logic               clk160,
    input  logic               rst,
    ttc_lock_ctrl_if.slave     bus,
    output logic               dec_rst,
    output logic               locked,
    output logic [7:0]         lock_loss_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned GOOD_W  = 8;
    localparam int unsigned ERR_W   = 4;
    localparam int unsigned GAP_W   = 8;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned RSTC_W  = 8;

    localparam logic [STATE_W-1:0] S_RESET_DEC = STATE_W'(RESET_DEC);
    localparam logic [STATE_W-1:0] S_SEARCH    = STATE_W'(SEARCH);
    localparam logic [STATE_W-1:0] S_CHECK     = STATE_W'(CHECK);
    localparam logic [STATE_W-1:0] S_LOCKED    = STATE_W'(LOCKED);

    logic [STATE_W-1:0] state_nxt;
    logic [RSTC_W-1:0]  rst_cnt,   rst_cnt_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic [GOOD_W-1:0]  good_cnt,  good_nxt;
    logic [ERR_W-1:0]   err_cnt,   err_nxt;
    logic [GAP_W-1:0]   gap_cnt,   gap_nxt;
    logic [7:0]         loss_nxt;

    logic [DWELL_W-1:0] dwell_inc;
    logic [GOOD_W-1:0]  good_inc;
    logic [ERR_W-1:0]   err_inc;
    logic [GAP_W-1:0]   gap_inc;
    logic               dwell_done;
    logic               lock_done;
    logic               is_sync;
    logic               good_sync;
    logic               gap_ovf;
    logic               lock_err;
    logic               fwd;

    logic               misspaced;
    logic               timeout;

    // Strobe spacing checker, held idle while the decoder is in reset
    ttc_word_spacing #(
        .WORD_PERIOD (WORD_PERIOD)
    ) u_spacing (
        .clk160    (clk160),
        .rst       (rst),
        .restart   (state == S_RESET_DEC),
        .valid     (bus.valid_in),
        .misspaced (misspaced),
        .timeout   (timeout)
    );

    // Next-state and counter logic
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        dwell_nxt   = dwell_cnt;
        good_nxt    = good_cnt;
        err_nxt     = err_cnt;
        gap_nxt     = gap_cnt;
        loss_nxt    = lock_loss_cnt;
        gap_ovf     = 1'b0;
        lock_err    = 1'b0;
        fwd         = 1'b0;

        is_sync    = (bus.data_in == SYNC_WORD);
        good_sync  = bus.valid_in && is_sync && !misspaced;
        dwell_inc  = dwell_cnt + DWELL_W'(1);
        dwell_done = (dwell_inc == DWELL_W'(SEARCH_TIMEOUT));
        good_inc   = good_cnt + GOOD_W'(1);
        lock_done  = good_sync && (good_inc == GOOD_W'(LOCK_COUNT));
        err_inc    = err_cnt + ERR_W'(1);
        gap_inc    = gap_cnt + GAP_W'(1);

        case (state)
            S_RESET_DEC: begin
                rst_cnt_nxt = rst_cnt + RSTC_W'(1);
                if (rst_cnt == RSTC_W'(RST_CYCLES - 1)) begin
                    state_nxt   = S_SEARCH;
                    rst_cnt_nxt = '0;
                end
            end

            // Completing lock wins over the dwell timeout in the same cycle
            S_SEARCH: begin
                dwell_nxt = dwell_inc;
                if (lock_done) begin
                    state_nxt = S_LOCKED;
                    good_nxt  = good_inc;
                end else if (dwell_done) begin
                    state_nxt = S_RESET_DEC;
                end else if (good_sync) begin
                    state_nxt = S_CHECK;
                    good_nxt  = good_inc;
                end
            end

            S_CHECK: begin
                dwell_nxt = dwell_inc;
                if (lock_done) begin
                    state_nxt = S_LOCKED;
                    good_nxt  = good_inc;
                end else if (dwell_done) begin
                    state_nxt = S_RESET_DEC;
                end else if (misspaced || timeout) begin
                    state_nxt = S_SEARCH;
                    good_nxt  = '0;
                end else if (good_sync) begin
                    good_nxt  = good_inc;
                end
            end

            S_LOCKED: begin
                // Every non-sync-qualified word advances the gap counter
                if (good_sync) begin
                    err_nxt = '0;
                    gap_nxt = '0;
                end else if (bus.valid_in) begin
                    if (gap_inc == GAP_W'(SYNC_GAP_MAX)) begin
                        gap_ovf = 1'b1;
                        gap_nxt = '0;
                    end else begin
                        gap_nxt = gap_inc;
                    end
                end

                // Coincident error sources count once
                lock_err = misspaced || timeout || gap_ovf;
                if (lock_err) begin
                    if (err_inc == ERR_W'(UNLOCK_COUNT)) begin
                        state_nxt = S_RESET_DEC;
                        loss_nxt  = sat_inc8(lock_loss_cnt);
                    end else begin
                        err_nxt = err_inc;
                    end
                end

`ifdef TTC_LOCK_SYNC_FILTER_EN
                fwd = bus.valid_in && !misspaced && !is_sync && (state_nxt == S_LOCKED);
`else
                fwd = bus.valid_in && !misspaced && (state_nxt == S_LOCKED);
`endif
            end

            default: begin
                state_nxt = S_RESET_DEC;
            end
        endcase

        // Entering RESET_DEC starts every counter from zero
        if ((state_nxt == S_RESET_DEC) && (state != S_RESET_DEC)) begin
            rst_cnt_nxt = '0;
            dwell_nxt   = '0;
            good_nxt    = '0;
            err_nxt     = '0;
            gap_nxt     = '0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk160) begin
        if (rst) begin
            state          <= S_RESET_DEC;
            rst_cnt        <= '0;
            dwell_cnt      <= '0;
            good_cnt       <= '0;
            err_cnt        <= '0;
            gap_cnt        <= '0;
            dec_rst        <= 1'b1;
            locked         <= 1'b0;
            lock_loss_cnt  <= '0;
            bus.word_valid <= 1'b0;
            bus.word_data  <= '0;
        end else begin
            state          <= state_nxt;
            rst_cnt        <= rst_cnt_nxt;
            dwell_cnt      <= dwell_nxt;
            good_cnt       <= good_nxt;
            err_cnt        <= err_nxt;
            gap_cnt        <= gap_nxt;
            dec_rst        <= (state_nxt == S_RESET_DEC);
            locked         <= (state_nxt == S_LOCKED);
            lock_loss_cnt  <= loss_nxt;
            bus.word_valid <= fwd;
            if (fwd) begin
                bus.word_data <= bus.data_in;
            end
        end
    end

endmodule

// File: tb/tb_ttc_lock_ctrl.sv
// tb_ttc_lock_ctrl: self-checking bench for ttc_lock_ctrl. A cycle-level
// reference model built from the lock/unlock rules runs alongside the DUT;
// directed steps check pulse widths, lock point, unlock timing and periods.
module tb_ttc_lock_ctrl;

    localparam int WP    = 8;
    localparam int LOCKC = 32;
    localparam int UNLK  = 4;
    localparam int GAPM  = 64;
    localparam int STO   = 4096;
    localparam int RSTC  = 16;
    localparam logic [15:0] SYNC = 16'h817E;

`ifdef TTC_LOCK_SYNC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    localparam int M_RD = 0, M_SEARCH = 1, M_CHECK = 2, M_LOCKED = 3;

    logic       clk160 = 1'b0;
    logic       rst;
    logic       dec_rst;
    logic       locked;
    logic [7:0] lock_loss_cnt;
    logic [1:0] state;

    ttc_lock_ctrl_if bus ();

    ttc_lock_ctrl #(
        .SYNC_WORD      (SYNC),
        .WORD_PERIOD    (WP),
        .LOCK_COUNT     (LOCKC),
        .UNLOCK_COUNT   (UNLK),
        .SYNC_GAP_MAX   (GAPM),
        .SEARCH_TIMEOUT (STO),
        .RST_CYCLES     (RSTC)
    ) dut (
        .clk160        (clk160),
        .rst           (rst),
        .bus           (bus),
        .dec_rst       (dec_rst),
        .locked        (locked),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state)
    );

    always #5 clk160 = ~clk160;

    int total = 0;
    int bad   = 0;

    // Reference model state (time-based view of the rules)
    int          now = 0;
    int          mode;
    int          last_ref;
    bit          have_prev;
    int          rd_start;
    int          search_start;
    int          goodc, errc, gapc, loss;
    bit          e_wv;
    logic [15:0] e_wd;
    bit          chk_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rnd_data();
        logic [15:0] x;
        x = 16'($urandom);
        if (x == SYNC) x = 16'h0001;
        return x;
    endfunction

    task automatic enter_rd();
        mode     = M_RD;
        rd_start = now + 1;
        goodc    = 0;
        errc     = 0;
        gapc     = 0;
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input logic r, input logic v, input logic [15:0] d);
        int elapsed;
        bit mis, tout, good, ovf;
        mis    = 1'b0;
        tout   = 1'b0;
        e_wv   = 1'b0;
        chk_wd = 1'b0;
        if (r) begin
            enter_rd();
            loss   = 0;
            e_wd   = 16'h0;
            chk_wd = 1'b1;
        end else begin
            if (mode != M_RD) begin
                elapsed = now - last_ref;
                mis  = v && have_prev && (elapsed != WP);
                tout = !v && (elapsed == 2 * WP);
                if (v) begin
                    last_ref  = now;
                    have_prev = 1'b1;
                end else if (tout) begin
                    last_ref = now;
                end
            end
            good = v && (d == SYNC) && !mis;
            case (mode)
                M_RD: begin
                    if (now - rd_start == RSTC - 1) begin
                        mode         = M_SEARCH;
                        search_start = now + 1;
                        last_ref     = now + 1;
                        have_prev    = 1'b0;
                    end
                end
                M_SEARCH, M_CHECK: begin
                    if (good && (goodc + 1 == LOCKC)) begin
                        mode = M_LOCKED;
                        errc = 0;
                        gapc = 0;
                    end else if (now - search_start + 1 == STO) begin
                        enter_rd();
                    end else if ((mode == M_CHECK) && (mis || tout)) begin
                        mode  = M_SEARCH;
                        goodc = 0;
                    end else if (good) begin
                        goodc++;
                        mode = M_CHECK;
                    end
                end
                default: begin
                    ovf = 1'b0;
                    if (good) begin
                        errc = 0;
                        gapc = 0;
                    end else if (v) begin
                        gapc++;
                        if (gapc == GAPM) begin
                            ovf  = 1'b1;
                            gapc = 0;
                        end
                    end
                    if (mis || tout || ovf) begin
                        errc++;
                        if (errc == UNLK) begin
                            enter_rd();
                            loss = (loss == 255) ? 255 : loss + 1;
                        end
                    end
                    if ((mode == M_LOCKED) && v && !mis && !(FILTER && (d == SYNC))) begin
                        e_wv   = 1'b1;
                        e_wd   = d;
                        chk_wd = 1'b1;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive inputs, step model, sample DUT 1 unit after the edge
    task automatic tick(input logic v, input logic [15:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
        model_step(rst, v, d);
        @(posedge clk160);
        #1;
        now++;
        chk("state",         32'(state),         32'(mode));
        chk("dec_rst",       32'(dec_rst),       32'(mode == M_RD));
        chk("locked",        32'(locked),        32'(mode == M_LOCKED));
        chk("word_valid",    32'(bus.word_valid), 32'(e_wv));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(loss));
        if (chk_wd) chk("word_data", 32'(bus.word_data), 32'(e_wd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, rnd_data());
    endtask

    task automatic strobe(input logic [15:0] d);
        tick(1'b1, d);
    endtask

    task automatic send_word(input logic [15:0] d, input int gap);
        strobe(d);
        idle(gap - 1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0);
        rst = 1'b0;
    endtask

    // Count consecutive samples with dec_rst high, starting at the current one
    task automatic measure_rst_pulse(input string tag);
        int n;
        n = 0;
        while ((dec_rst === 1'b1) && (n < 100)) begin
            n++;
            idle(1);
        end
        chk(tag, 32'(n), 32'(RSTC));
    endtask

    task automatic clean_stream(input int n_syncs);
        for (int s = 0; s < n_syncs; s++) begin
            send_word(SYNC, WP);
            for (int w = 0; w < 3; w++) send_word(16'h1234, WP);
        end
    endtask

    initial begin
        int k, rise1, rise2, nrise, t0;
        bit seen_lock;
        logic prev_dr;

        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 16'h0;

        // Reset values and decoder reset pulse width
        do_reset(3);
        chk("rst_dec_rst",    32'(dec_rst),        32'd1);
        chk("rst_state",      32'(state),          32'd0);
        chk("rst_locked",     32'(locked),         32'd0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word_data",  32'(bus.word_data),  32'd0);
        chk("rst_loss",       32'(lock_loss_cnt),  32'd0);
        measure_rst_pulse("rst_pulse_len");

        // Clean stream: lock on the 32nd sync, data forwarded one cycle later
        for (int s = 1; s <= LOCKC; s++) begin
            strobe(SYNC);
            chk("locked_vs_sync", 32'(locked), (s == LOCKC) ? 32'd1 : 32'd0);
            chk("lock_strobe_fwd", 32'(bus.word_valid), 32'd0);
            idle(WP - 1);
            for (int w = 0; w < 3; w++) begin
                strobe(16'h1234);
                if (s == LOCKC) begin
                    chk("fwd_valid", 32'(bus.word_valid), 32'd1);
                    chk("fwd_data",  32'(bus.word_data),  32'h1234);
                end
                idle(WP - 1);
            end
        end

        // One short period: single error, not forwarded, lock kept
        send_word(16'h1234, WP - 1);
        strobe(16'h1234);
        chk("misspaced_not_fwd", 32'(bus.word_valid), 32'd0);
        chk("misspaced_locked",  32'(locked),         32'd1);
        idle(WP - 1);
        clean_stream(2);
        chk("glitch_locked", 32'(locked),        32'd1);
        chk("glitch_loss",   32'(lock_loss_cnt), 32'd0);

        // 70 words without sync: one gap error, no unlock
        for (int w = 0; w < 70; w++) send_word(rnd_data(), WP);
        clean_stream(2);
        chk("gap_locked", 32'(locked),        32'd1);
        chk("gap_loss",   32'(lock_loss_cnt), 32'd0);

        // Sync word forwarding depends on the build option
        strobe(SYNC);
        chk("sync_fwd", 32'(bus.word_valid), FILTER ? 32'd0 : 32'd1);
        idle(WP - 1);

        // Randomised traffic with occasional jitter, checked by the model
        for (int w = 0; w < 400; w++) begin
            k = WP;
            if ($urandom_range(31, 0) == 0) k = ($urandom_range(1, 0) == 0) ? WP - 1 : WP + 1;
            send_word(($urandom_range(3, 0) == 0) ? SYNC : rnd_data(), k);
        end

        // Relock from scratch, then stop the stream: unlock on the 4th timeout
        do_reset(1);
        measure_rst_pulse("rst_pulse_len2");
        clean_stream(LOCKC + 1);
        chk("relock", 32'(locked), 32'd1);
        strobe(16'h1234);
        k = 0;
        while ((locked === 1'b1) && (k < 100)) begin
            k++;
            idle(1);
        end
        chk("unlock_after_timeouts", 32'(k), 32'(UNLK * 2 * WP));
        measure_rst_pulse("unlock_rst_pulse");
        chk("loss_after_unlock", 32'(lock_loss_cnt), 32'd1);

        // Lock again, then reset mid-LOCKED, then reset mid-pulse
        clean_stream(LOCKC + 1);
        chk("relock2", 32'(locked), 32'd1);
        do_reset(1);
        chk("midrst_dec_rst",    32'(dec_rst),        32'd1);
        chk("midrst_state",      32'(state),          32'd0);
        chk("midrst_locked",     32'(locked),         32'd0);
        chk("midrst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("midrst_word_data",  32'(bus.word_data),  32'd0);
        chk("midrst_loss",       32'(lock_loss_cnt),  32'd0);
        idle(5);
        do_reset(1);
        measure_rst_pulse("rst_in_pulse_len");

        // No sync ever: RESET_DEC re-entered every RST_CYCLES+SEARCH_TIMEOUT
        do_reset(1);
        t0        = now;
        prev_dr   = dec_rst;
        rise1     = 0;
        rise2     = 0;
        nrise     = 0;
        seen_lock = 1'b0;
        for (int c = 0; c < 2 * (STO + RSTC) + 20; c++) begin
            tick(($urandom_range(7, 0) == 0), rnd_data());
            if (locked === 1'b1) seen_lock = 1'b1;
            if ((prev_dr === 1'b0) && (dec_rst === 1'b1)) begin
                nrise++;
                if (nrise == 1) rise1 = now;
                if (nrise == 2) rise2 = now;
            end
            prev_dr = dec_rst;
        end
        chk("nosync_rises",   32'(nrise),      32'd2);
        chk("nosync_first",   32'(rise1 - t0), 32'(STO + RSTC));
        chk("nosync_period",  32'(rise2 - rise1), 32'(STO + RSTC));
        chk("nosync_no_lock", 32'(seen_lock),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
